i2s_adc_receiver: RTL
=====================

# i2s_adc_receiver

Slave-mode I2S receiver for the WM8731 ADC path; the capture-side counterpart of the DAC sender. It takes codec-driven BCLK, ADCLRC and ADCDAT, which are asynchronous to CLK. It synchronises them into the 50 MHz CLK domain, deserialises one stereo frame (left word, then right word), and presents the pair on a valid/ready interface to the downstream RAM or FIFO writer.

## Interface
- DATA_W, 24: sample width captured per channel.
- SYNC_STAGES, 2: synchroniser flops per input pin; legal values are 2 or 3.
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  asynchronous, active-low reset.
- BCLK  in  1  codec bit clock, asynchronous; each level lasts ≥2 CLK periods.
- ADCLRC  in  1  codec word select; 0 = left, 1 = right.
- ADCDAT  in  1  codec serial data, MSB first.
- L_DATA  out  DATA_W  left sample of the held pair.
- R_DATA  out  DATA_W  right sample of the held pair.
- DATA_VALID  out  1  the held pair is available.
- DATA_READY  in  1  consumer accepts the pair.
- OVERFLOW  out  1  sticky flag: a completed pair was dropped.
- OVF_CLR  in  1  synchronous clear for OVERFLOW.
- FRAME_ERR  out  1  one-CLK pulse per bad pair; tied to 0 unless the frame-check macro is defined.

## Operation
- All three pins pass through SYNC_STAGES flops. One further BCLK flop provides rising-edge detection (`brise`).
- On every `brise`, the block samples `lrc` and `dat` together. `lrc` is compared with its value at the previous `brise`.
- One-bit delay, standard I2S:
  - The bit sampled on the `brise` where `lrc` changes belongs to the old channel.
  - The new word starts on the next `brise`.
- States:
  - IDLE: entered from reset. Moves to LEFT on the first `lrc` 1→0 change. Partial words are discarded.
  - LEFT: moves to RIGHT on a 0→1 change, after storing the bit that completes the left word.
  - RIGHT: on a 1→0 change, stores its last bit, completes the pair, and returns to LEFT.
- Shifting:
  - The shift register captures the first DATA_W bits of each word; later bits in the slot are ignored.
  - The bit counter is 6 bits wide and saturates at 63.
  - A word shorter than DATA_W bits is left-aligned, with the LSBs zero-filled.
- Pair completion (`done`):
  - If the output is empty (DATA_VALID=0), or DATA_READY=1 in that same cycle: load L_DATA/R_DATA and set DATA_VALID.
  - Otherwise, drop the new pair, keep the held pair unchanged, and set OVERFLOW.
- Handshake:
  - L_DATA/R_DATA are stable while DATA_VALID=1.
  - A transfer occurs in any cycle with DATA_VALID & DATA_READY.
  - DATA_VALID falls after a transfer unless a pair is loaded in that same cycle.
- OVF_CLR clears OVERFLOW. If OVF_CLR and a new overflow occur in the same cycle, set wins.

## Timing
- Reset values: L_DATA=0, R_DATA=0, DATA_VALID=0, OVERFLOW=0, FRAME_ERR=0, state=IDLE, counters=0, synchronisers=0.
- Input latency: a codec edge produces `brise` SYNC_STAGES+1 to SYNC_STAGES+2 CLK periods later.
- Output latency: DATA_VALID rises one CLK after the `brise` that completes the right word.
- Throughput: one pair per LRC period. A pair must be accepted within one frame, otherwise OVERFLOW is set.
- Reset mid-frame: all state is cleared immediately, the in-flight pair is lost, and the block waits in IDLE for the next left-start.
- BCLK stopped: no output activity. State is held.

## Configuration
- I2S_RX_FRAME_CHECK_EN defined:
  - Each word's slot length is checked; a slot is bad if its length is <DATA_W or >32 bits.
  - If either word of a pair is bad, FRAME_ERR pulses one CLK, coincident with the load attempt. This happens whether the pair is loaded or dropped.
  - The pair is still delivered.
- Macro undefined: FRAME_ERR is constant 0 and the length-check logic is absent.

## Structure
- Package `i2s_pkg` holds:
  - DATA_W default.
  - The state enum (IDLE, LEFT, RIGHT).
  - Bit-counter width: 6.
  - Maximum slot length: 32.
- Sub-module `i2s_sync_edge`: a SYNC_STAGES synchroniser plus a rising-edge pulse. Instantiated for BCLK; ADCLRC and ADCDAT use synchroniser-only instances.

## Test plan
- Normal capture: 64-BCLK frames at CLK/4, L=24'hA5A5A5, R=24'h123456, DATA_READY held 1 → one DATA_VALID pulse per frame with exact values; FRAME_ERR=0.
- Start alignment: release reset mid-right-word → the first partial frame is discarded, and the first pair delivered is the next full frame.
- Backpressure: DATA_READY=0 for two frames → the first pair is held, the second is dropped, OVERFLOW=1. Then DATA_READY=1 → the first pair transfers. OVF_CLR → OVERFLOW=0.
- Simultaneous events:
  - DATA_READY=1 in the same cycle as the next `done` → the new pair is loaded, DATA_VALID stays 1, no overflow.
  - OVF_CLR together with an overflow → OVERFLOW=1.
- Short word: 20-bit slots carrying 0xFFFFF → L_DATA=24'hFFFFF0. With I2S_RX_FRAME_CHECK_EN, FRAME_ERR pulses once per pair.
- Reset mid-word: assert RST during left-word bit 10 → all outputs 0 at once; after release, the next complete frame is captured correctly.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S ADC capture path.
package i2s_pkg;

    localparam int unsigned DATA_W_DEF = 24;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned MAX_SLOT   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

endpackage

// File: rtl/i2s_adc_receiver_sync_edge.sv
// Multi-flop synchroniser for one codec pin, with an optional rising-edge pulse.
module i2s_sync_edge
    import i2s_pkg::*;
#(
    parameter int unsigned STAGES  = 2,
    parameter bit          EDGE_EN = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q,
    output logic rise_c
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) chain <= '0;
        else      chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev;
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) prev <= 1'b0;
                else      prev <= q;
            end
            assign rise_c = q & ~prev;
        end else begin : g_no_edge
            assign rise_c = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/i2s_adc_receiver.sv
// Slave-mode I2S capture of one stereo pair per LRC frame onto a valid/ready port.
// Optional slot-length checking is compiled in with I2S_RX_FRAME_CHECK_EN.
module i2s_adc_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BCLK,
    input  logic              ADCLRC,
    input  logic              ADCDAT,
    output logic [DATA_W-1:0] L_DATA,
    output logic [DATA_W-1:0] R_DATA,
    output logic              DATA_VALID,
    input  logic              DATA_READY,
    output logic              OVERFLOW,
    input  logic              OVF_CLR,
    output logic              FRAME_ERR
);

    logic brise_c, lrc, dat;
    logic bclk_lvl_unused, lrc_rise_unused, dat_rise_unused;

    i2s_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_bclk (
        .CLK(CLK), .RST(RST), .d(BCLK), .q(bclk_lvl_unused), .rise_c(brise_c));
    i2s_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_lrc (
        .CLK(CLK), .RST(RST), .d(ADCLRC), .q(lrc), .rise_c(lrc_rise_unused));
    i2s_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_dat (
        .CLK(CLK), .RST(RST), .d(ADCDAT), .q(dat), .rise_c(dat_rise_unused));

    state_t             state, state_nx;
    logic               lrc_prev;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  sreg, word_c, l_word;
    logic               lrc_up_c, lrc_dn_c;
    logic               shift_en_c, left_done_c, pair_done_c, load_c;

    assign lrc_up_c = brise_c & ~lrc_prev &  lrc;
    assign lrc_dn_c = brise_c &  lrc_prev & ~lrc;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (lrc_dn_c) state_nx = LEFT;
            LEFT:    if (lrc_up_c) state_nx = RIGHT;
            RIGHT:   if (lrc_dn_c) state_nx = LEFT;
            default: state_nx = IDLE;
        endcase
    end

    // The bit on an LRC change still belongs to the word being closed.
    always_comb begin
        shift_en_c  = 1'b0;
        left_done_c = 1'b0;
        pair_done_c = 1'b0;
        case (state)
            LEFT: begin
                shift_en_c  = brise_c;
                left_done_c = lrc_up_c;
            end
            RIGHT: begin
                shift_en_c  = brise_c;
                pair_done_c = lrc_dn_c;
            end
            default: ;
        endcase
    end

    // Place the current bit by position so short words end up left-aligned.
    always_comb begin
        word_c = sreg;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (cnt == CNT_W'(int'(DATA_W) - 1 - i)) word_c[i] = dat;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lrc_prev <= 1'b0;
            sreg     <= '0;
            cnt      <= '0;
            l_word   <= '0;
        end else if (brise_c) begin
            lrc_prev <= lrc;
            if (left_done_c || pair_done_c) begin
                sreg <= '0;
                cnt  <= '0;
            end else if (shift_en_c) begin
                sreg <= word_c;
                cnt  <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
            end
            if (left_done_c) l_word <= word_c;
        end
    end

    assign load_c = pair_done_c & (~DATA_VALID | DATA_READY);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            L_DATA     <= '0;
            R_DATA     <= '0;
            DATA_VALID <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            if (load_c) begin
                L_DATA     <= l_word;
                R_DATA     <= word_c;
                DATA_VALID <= 1'b1;
            end else if (DATA_READY) begin
                DATA_VALID <= 1'b0;
            end
            if (pair_done_c && !load_c) OVERFLOW <= 1'b1;
            else if (OVF_CLR)           OVERFLOW <= 1'b0;
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    // cnt holds the bits before the closing one, so slot length is cnt+1.
    logic slot_bad_c, l_bad;

    assign slot_bad_c = (cnt < CNT_W'(DATA_W - 1)) || (cnt >= CNT_W'(MAX_SLOT));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            l_bad     <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            if (left_done_c) l_bad <= slot_bad_c;
            FRAME_ERR <= pair_done_c & (l_bad | slot_bad_c);
        end
    end
`else
    assign FRAME_ERR = 1'b0;
`endif

endmodule
